shift_burst_reg: RTL and testbench
==================================

# shift_burst_reg

Parametrised bidirectional shift register with parallel load, a single-step manual shift, and an autonomous burst engine that performs a programmed number of shifts after a one-cycle start pulse. It serves as the general-purpose serialiser/deserialiser in the datapath and is the successor of the fixed 4-bit right-shift register. Outputs report busy and a one-cycle done pulse to the issuing controller.

## Interface
- N, 8, register width (≥2)
- CNT_W, $clog2(N+1), burst-count width (derived; not overridden)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- pl  input  1  parallel load of din
- din  input  N  parallel load data
- en  input  1  manual single-bit shift
- dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward bit N-1)
- si  input  1  serial input bit
- rot  input  1  rotate select (effective only with SHIFT_BURST_ROTATE_EN)
- start  input  1  start burst; sampled only in IDLE/DONE
- cnt  input  CNT_W  burst shift count
- reg_out  output  N  register contents
- so  output  1  last bit shifted out
- busy  output  1  burst in progress
- done  output  1  one-cycle burst-completion pulse

## Operation
- Reset (rst=0, asynchronous): reg_out=0, so=0, busy=0, done=0, state=IDLE, counter=0.
- Shift right: reg_out ← {fill, reg_out[N-1:1]}, so ← reg_out[0]. Shift left: reg_out ← {reg_out[N-2:0], fill}, so ← reg_out[N-1]. fill = si, or the bit leaving when rotating.
- Priority at each edge: pl > start > en.
- pl: reg_out ← din; so unchanged. If busy, the burst aborts: state→IDLE, busy→0, no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: latch dir, rot, and count = min(cnt, N). count=0 → DONE; else → RUN with counter=count.
  - IDLE/DONE + en (no start): one shift per edge; state unchanged, except DONE→IDLE.
  - DONE with no start → IDLE.
  - RUN: one shift per edge using the latched dir/rot and live si; counter decrements; on the shift that takes counter to 0 → DONE.
  - In RUN, start and en are ignored.
- busy = (state==RUN). done = (state==DONE).
- cnt > N saturates to N.

## Timing
- Manual shift/load: result is visible on reg_out/so after the sampling edge (latency 1).
- Burst with start at edge k and count c≥1: shifts occur on edges k+1 … k+c. busy is high from after edge k through after edge k+c-1. done is high for one cycle after edge k+c.
- Burst with c=0: done is high the cycle after edge k; no shift occurs.
- Back-to-back bursts: start during DONE enters RUN with no IDLE cycle. done drops, busy rises.
- Reset mid-burst clears everything immediately. No done is issued.

## Configuration
- SHIFT_BURST_ROTATE_EN defined: rot=1 makes fill the bit leaving the register (rotate); si is ignored, and so still reports the leaving bit.
- SHIFT_BURST_ROTATE_EN undefined: rot is ignored and fill is always si. No rotate logic is synthesised.

## Structure
- Package shift_burst_pkg: state typedef (IDLE, RUN, DONE), direction constants DIR_RIGHT=1'b0 and DIR_LEFT=1'b1.
- Sub-module shift_burst_ctrl: FSM, down-counter, saturation, busy/done generation. It emits a per-cycle shift strobe plus the effective dir/rot. The top level holds the register datapath and the pl/en muxing.

## Test plan
- Reset/load: hold rst=0 then release; pl with din=8'hA5 → reg_out=8'hA5, so=0, busy=0, done=0.
- Manual: reg_out=8'hA5, en=1, dir=0, si=1, one edge → reg_out=8'hD2, so=1; then dir=1, si=0 → reg_out=8'hA4, so=1.
- Burst: reg_out=8'hF0, start with cnt=4, dir=0, si=0 → busy for 4 cycles, then reg_out=8'h0F, so=0, done high exactly 1 cycle; en pulses issued during busy have no effect.
- Edge counts: cnt=0 → done next cycle, reg_out unchanged. cnt=15 (N=8) → exactly 8 shifts, then done.
- Abort/priority: pl with din=8'h3C at the 2nd RUN cycle → reg_out=8'h3C, busy=0, no done. rst low mid-burst → all outputs 0 immediately.
- Rotate (with SHIFT_BURST_ROTATE_EN): reg_out=8'h81, start with cnt=1, dir=1, rot=1 → reg_out=8'h03, so=1. Without the macro, the same stimulus with si=0 → reg_out=8'h02.

Source files
------------

// File: rtl/shift_burst_pkg.sv
// Shared types and constants for the shift_burst_reg block.
package shift_burst_pkg;

   // Burst engine states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift direction encoding on the dir input
   localparam logic DIR_RIGHT = 1'b0;  // toward bit 0
   localparam logic DIR_LEFT  = 1'b1;  // toward bit N-1

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller for shift_burst_reg: FSM, saturating down-counter and
// busy/done generation. Emits a per-cycle shift strobe together with the
// direction and rotate select that apply to that shift.
// Optional feature macro: SHIFT_BURST_ROTATE_EN (latches and forwards rot).
//
// Handshake: start is sampled only while the engine is not busy
// (IDLE/DONE). busy is high from the cycle after an accepted start until
// the last shift edge; done pulses for exactly one cycle after the last
// shift (or the cycle after start when the count is 0). pl overrides
// everything and aborts a burst without a done pulse.
import shift_burst_pkg::*;

module shift_burst_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pl,
   input  logic             start,
   input  logic             en,
   input  logic             dir,
   input  logic             rot,
   input  logic [CNT_W-1:0] cnt,
   output logic             shift,
   output logic             shift_dir,
   output logic             shift_rot,
   output logic             busy,
   output logic             done,
   output state_t           state
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dir_q;
   logic [CNT_W-1:0] cnt_sat;

   assign state   = state_q;
   assign cnt_sat = (cnt > CNT_MAX) ? CNT_MAX : cnt;

   // Burst FSM with latched parameters and registered busy/done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dir_q   <= DIR_RIGHT;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (pl) begin
         // Parallel load aborts any burst silently
         state_q <= IDLE;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               // IDLE and DONE behave alike; DONE always falls back to IDLE
               if (start) begin
                  dir_q <= dir;
                  cnt_q <= cnt_sat;
                  if (cnt_sat == '0) begin
                     state_q <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy    <= 1'b1;
                     done    <= 1'b0;
                  end
               end else begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
         endcase
      end
   end

   // Shift strobe: every RUN cycle, or a manual en when no start competes
   always_comb begin
      shift     = 1'b0;
      shift_dir = dir;
      if (!pl) begin
         if (state_q == RUN) begin
            shift     = 1'b1;
            shift_dir = dir_q;
         end else if (!start && en) begin
            shift = 1'b1;
         end
      end
   end

`ifdef SHIFT_BURST_ROTATE_EN
   logic rot_q;

   // Rotate select is latched at burst start like the direction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rot_q <= 1'b0;
      end else if (!pl && state_q != RUN && start) begin
         rot_q <= rot;
      end
   end

   assign shift_rot = (state_q == RUN) ? rot_q : rot;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign shift_rot  = 1'b0;
`endif

endmodule

// File: rtl/shift_burst_reg.sv
// Parametrised bidirectional shift register with parallel load, manual
// single-step shift and an autonomous burst engine (shift_burst_ctrl).
// Optional feature macro: SHIFT_BURST_ROTATE_EN (rot=1 recirculates the
// leaving bit instead of si).
import shift_burst_pkg::*;

module shift_burst_reg #(
   parameter  int N     = 8,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pl,
   input  logic [N-1:0]     din,
   input  logic             en,
   input  logic             dir,
   input  logic             si,
   input  logic             rot,
   input  logic             start,
   input  logic [CNT_W-1:0] cnt,
   output logic [N-1:0]     reg_out,
   output logic             so,
   output logic             busy,
   output logic             done
);

   logic   shift;
   logic   shift_dir;
   logic   shift_rot;
   logic   leaving;
   logic   fill;
   // FSM state, kept as a probe point for bound checkers
   state_t unused_ctrl_state;

   shift_burst_ctrl #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .pl        (pl),
      .start     (start),
      .en        (en),
      .dir       (dir),
      .rot       (rot),
      .cnt       (cnt),
      .shift     (shift),
      .shift_dir (shift_dir),
      .shift_rot (shift_rot),
      .busy      (busy),
      .done      (done),
      .state     (unused_ctrl_state)
   );

   assign leaving = (shift_dir == DIR_RIGHT) ? reg_out[0] : reg_out[N-1];

`ifdef SHIFT_BURST_ROTATE_EN
   assign fill = shift_rot ? leaving : si;
`else
   logic unused_shift_rot;
   assign unused_shift_rot = shift_rot;
   assign fill             = si;
`endif

   // Register datapath: load has priority, then the controller's shift strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_out <= '0;
         so      <= 1'b0;
      end else if (pl) begin
         reg_out <= din;
      end else if (shift) begin
         so <= leaving;
         if (shift_dir == DIR_RIGHT) begin
            reg_out <= {fill, reg_out[N-1:1]};
         end else begin
            reg_out <= {reg_out[N-2:0], fill};
         end
      end
   end

endmodule

// File: tb/tb_shift_burst_reg.sv
// Directed testbench for shift_burst_reg (N=8).
module tb_shift_burst_reg;

   localparam int N     = 8;
   localparam int CNT_W = $clog2(N + 1);

   logic             clk;
   logic             rst;
   logic             pl;
   logic [N-1:0]     din;
   logic             en;
   logic             dir;
   logic             si;
   logic             rot;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     reg_out;
   logic             so;
   logic             busy;
   logic             done;

   int tests_run;
   int tests_failed;
   int steps;
   logic [N-1:0] rot_exp;

   shift_burst_reg #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .pl      (pl),
      .din     (din),
      .en      (en),
      .dir     (dir),
      .si      (si),
      .rot     (rot),
      .start   (start),
      .cnt     (cnt),
      .reg_out (reg_out),
      .so      (so),
      .busy    (busy),
      .done    (done)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [N-1:0] val);
      pl  = 1'b1;
      din = val;
      step();
      pl  = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst   = 1'b0;
      pl    = 1'b0;
      din   = '0;
      en    = 1'b0;
      dir   = 1'b0;
      si    = 1'b0;
      rot   = 1'b0;
      start = 1'b0;
      cnt   = '0;

      // Reset
      step();
      step();
      check("rst_reg",  reg_out, 0);
      check("rst_so",   so,      0);
      check("rst_busy", busy,    0);
      check("rst_done", done,    0);
      rst = 1'b1;
      step();

      // Parallel load
      load(8'hA5);
      check("load_reg",  reg_out, 8'hA5);
      check("load_so",   so,      0);
      check("load_busy", busy,    0);
      check("load_done", done,    0);

      // Manual shifts
      en = 1'b1; dir = 1'b0; si = 1'b1;
      step();
      check("man_r_reg", reg_out, 8'hD2);
      check("man_r_so",  so,      1);
      dir = 1'b1; si = 1'b0;
      step();
      check("man_l_reg", reg_out, 8'hA4);
      check("man_l_so",  so,      1);
      en = 1'b0;

      // Burst of 4 right shifts, en toggled while busy
      load(8'hF0);
      start = 1'b1; cnt = 4'd4; dir = 1'b0; si = 1'b0;
      step();
      start = 1'b0;
      check("b4_busy0", busy,    1);
      check("b4_reg0",  reg_out, 8'hF0);
      en = 1'b1; dir = 1'b1;
      step();
      check("b4_reg1",  reg_out, 8'h78);
      check("b4_busy1", busy,    1);
      step();
      check("b4_busy2", busy,    1);
      check("b4_done2", done,    0);
      step();
      check("b4_busy3", busy,    1);
      en = 1'b0;
      step();
      check("b4_reg",  reg_out, 8'h0F);
      check("b4_so",   so,      0);
      check("b4_done", done,    1);
      check("b4_busy", busy,    0);
      step();
      check("b4_done_drop", done, 0);

      // Zero-length burst
      start = 1'b1; cnt = 4'd0;
      step();
      start = 1'b0;
      check("b0_done", done,    1);
      check("b0_busy", busy,    0);
      check("b0_reg",  reg_out, 8'h0F);
      step();
      check("b0_done_drop", done, 0);

      // Saturated burst: cnt=15 shifts 8 times
      load(8'h01);
      start = 1'b1; cnt = 4'd15; dir = 1'b1; si = 1'b0;
      step();
      start = 1'b0;
      steps = 0;
      while (!done && steps < 20) begin
         step();
         steps++;
      end
      check("sat_steps", steps,   8);
      check("sat_done",  done,    1);
      check("sat_reg",   reg_out, 8'h00);
      check("sat_so",    so,      1);

      // Back-to-back: start while in DONE
      start = 1'b1; cnt = 4'd2; dir = 1'b0; si = 1'b1;
      step();
      start = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_done", done, 0);
      step();
      step();
      check("b2b_reg",  reg_out, 8'hC0);
      check("b2b_so",   so,      0);
      check("b2b_fin",  done,    1);
      si = 1'b0;
      step();

      // Abort by pl on the second RUN cycle
      load(8'h55);
      start = 1'b1; cnt = 4'd5; dir = 1'b0; si = 1'b0;
      step();
      start = 1'b0;
      step();
      check("abort_reg1", reg_out, 8'h2A);
      pl = 1'b1; din = 8'h3C;
      step();
      pl = 1'b0;
      check("abort_reg",  reg_out, 8'h3C);
      check("abort_busy", busy,    0);
      check("abort_done", done,    0);
      step();
      check("abort_nodone", done,    0);
      check("abort_hold",   reg_out, 8'h3C);

      // Reset mid-burst
      start = 1'b1; cnt = 4'd8; dir = 1'b0; si = 1'b1;
      step();
      start = 1'b0;
      step();
      check("mid_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_reg",  reg_out, 0);
      check("mid_rst_so",   so,      0);
      check("mid_rst_busy", busy,    0);
      check("mid_rst_done", done,    0);
      rst = 1'b1;
      si  = 1'b0;
      step();
      check("post_rst_busy", busy,    0);
      check("post_rst_done", done,    0);
      check("post_rst_reg",  reg_out, 0);

      // Rotate select (recirculates only with the rotate build)
      load(8'h81);
      start = 1'b1; cnt = 4'd1; dir = 1'b1; rot = 1'b1; si = 1'b0;
      step();
      start = 1'b0; rot = 1'b0;
      step();
`ifdef SHIFT_BURST_ROTATE_EN
      rot_exp = 8'h03;
`else
      rot_exp = 8'h02;
`endif
      check("rot_reg",  reg_out, rot_exp);
      check("rot_so",   so,      1);
      check("rot_done", done,    1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
